imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader_byte_packer.sv | 37 +++
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// stream-format constants.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    ERR
  } state_t;

  localparam int LEN_W      = 16;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: byte-stream input, word write port to instruction memory, status.
interface imem_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word_full/word are combinational so the
// parent can register the write on the same edge that takes the last byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_full,
  output logic [31:0] word
);

  logic [LANE_W-1:0] lane;
  logic [23:0]       low;

  assign word_full = byte_valid && (lane == LANE_W'(WORD_BYTES - 1));
  assign word      = {byte_data, low};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      lane <= '0;
      low  <= '0;
    end else if (byte_valid) begin
      // The top lane is never stored; it goes straight into word.
      lane <= lane + LANE_W'(1);
      case (lane)
        2'd0:    low[7:0]   <= byte_data;
        2'd1:    low[15:8]  <= byte_data;
        2'd2:    low[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses length / payload / checksum from a byte stream and writes
// 32-bit words into instruction memory while holding the core's PC in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  state_t           state;
  logic             in_ready, busy, done, error;
  logic             wr_en;
  logic [31:0]      wr_addr, wr_data;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] word_cnt, word_idx;
  logic [7:0]       acc;

  logic             xfer, pk_valid, pk_clr, word_full;
  logic [31:0]      word;
  logic [LEN_W-1:0] len;

  assign xfer     = bus.in_valid && in_ready;
  assign pk_valid = xfer && (state == DATA);
  assign pk_clr   = bus.start && (state == IDLE || state == ERR);
  assign len      = {bus.in_data, len_lo};

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .byte_data  (bus.in_data),
    .word_full  (word_full),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      len_lo   <= '0;
      word_cnt <= '0;
      word_idx <= '0;
      acc      <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE, ERR: begin
          if (bus.start) begin
            state    <= LEN_LO;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            error    <= 1'b0;
            word_idx <= '0;
            acc      <= '0;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_lo <= bus.in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            if (len == '0 || len > LEN_W'(MAX_WORDS)) begin
              state    <= ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              word_cnt <= len;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            acc <= acc ^ bus.in_data;
            if (word_full) begin
              wr_en    <= 1'b1;
              wr_data  <= word;
              wr_addr  <= ADDR_BASE + {14'd0, word_idx, 2'b00};
              word_idx <= word_idx + 1'b1;
              // Checksum byte can only arrive next cycle, so done lags the last write.
              if (word_idx == word_cnt - 1'b1) state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (bus.in_data == acc) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              error <= 1'b1;
              state <= ERR;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.error    = error;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 0x100) share one stream;
// a parse-level reference model predicts writes, done and error per load.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int          MAXW  = 4;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;
  localparam logic [7:0]  IMG [16] = '{8'h03, 8'h13, 8'hC4, 8'hFF, 8'h23, 8'hA4, 8'h64, 8'h00,
                                       8'h33, 8'hE2, 8'h62, 8'h00, 8'hE3, 8'h0A, 8'h42, 8'hFE};
  localparam logic [63:0] SPEC_W [4] = '{{32'h0, 32'hFFC41303}, {32'h4, 32'h0064A423},
                                         {32'h8, 32'h0062E233}, {32'hC, 32'hFE420AE3}};

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  always #5 clk = ~clk;

  imem_loader_if b0 ();
  imem_loader_if b1 ();
  assign b0.start = start;  assign b0.in_valid = in_valid;  assign b0.in_data = in_data;
  assign b1.start = start;  assign b1.in_valid = in_valid;  assign b1.in_data = in_data;

  imem_loader #(.ADDR_BASE(BASE0), .MAX_WORDS(MAXW)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  imem_loader #(.ADDR_BASE(BASE1), .MAX_WORDS(MAXW)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: collect writes and done pulses away from the active edge.
  logic [63:0] got0[$], got1[$];
  int          done0 = 0, done1 = 0, cyc = 0, last_wr0 = -1, last_wr1 = -1;

  always @(negedge clk) begin
    cyc++;
    if (b0.wr_en) begin got0.push_back({b0.wr_addr, b0.wr_data}); last_wr0 = cyc; end
    if (b1.wr_en) begin got1.push_back({b1.wr_addr, b1.wr_data}); last_wr1 = cyc; end
    if (b0.done) begin done0++; chk("wr_before_done0", 64'(last_wr0 < cyc), 64'd1); end
    if (b1.done) begin done1++; chk("wr_before_done1", 64'(last_wr1 < cyc), 64'd1); end
  end

  // Reference model over the bytes actually delivered.
  logic [7:0]  stream[$];
  logic [63:0] exp0[$], exp1[$];
  bit          exp_done, exp_err;

  task automatic model(input int cnt);
    int         n;
    logic [7:0] x;
    exp0.delete(); exp1.delete();
    exp_done = 1'b0; exp_err = 1'b0; x = 8'h00;
    if (cnt < 2) return;
    n = int'({stream[1], stream[0]});
    if (n == 0 || n > MAXW) begin exp_err = 1'b1; return; end
    for (int w = 0; w < n && cnt >= 2 + 4 * (w + 1); w++) begin
      logic [31:0] d;
      d = {stream[2+4*w+3], stream[2+4*w+2], stream[2+4*w+1], stream[2+4*w]};
      exp0.push_back({BASE0 + 32'(4 * w), d});
      exp1.push_back({BASE1 + 32'(4 * w), d});
    end
    for (int k = 2; k < cnt && k < 2 + 4 * n; k++) x ^= stream[k];
    if (cnt == 3 + 4 * n) begin
      if (stream[cnt-1] == x) exp_done = 1'b1;
      else                    exp_err  = 1'b1;
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", {62'd0, b1.in_ready, b0.in_ready}, 64'd0);
    chk("rst_wr_en",    {62'd0, b1.wr_en,    b0.wr_en},    64'd0);
    chk("rst_wr_addr",  {b1.wr_addr, b0.wr_addr},          64'd0);
    chk("rst_wr_data",  {b1.wr_data, b0.wr_data},          64'd0);
    chk("rst_busy",     {62'd0, b1.busy,  b0.busy},        64'd0);
    chk("rst_done",     {62'd0, b1.done,  b0.done},        64'd0);
    chk("rst_error",    {62'd0, b1.error, b0.error},       64'd0);
  endtask

  // gaps: 0 back-to-back, 1 random idle cycles, 2 idle between every byte.
  task automatic load(input int gaps, input int mid_start, input int stop_at);
    int n_sent;
    got0.delete(); got1.delete(); done0 = 0; done1 = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n_sent = (stop_at >= 0 && stop_at < stream.size()) ? stop_at : stream.size();
    for (int i = 0; i < n_sent; i++) begin
      int guard = 0;
      if (gaps == 2 || (gaps == 1 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0; @(negedge clk);
      end
      in_valid = 1'b1; in_data = stream[i];
      if (i == mid_start) start = 1'b1;
      while (b0.in_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      if (guard >= 20) begin chk("ready_timeout", 64'd0, 64'd1); break; end
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (stop_at >= 0) begin
      reset = 1'b1; @(negedge clk);
      check_reset_vals();
      reset = 1'b0;
    end
    repeat (4) @(negedge clk);
    model(n_sent);
    chk("wr_count0", 64'(got0.size()), 64'(exp0.size()));
    chk("wr_count1", 64'(got1.size()), 64'(exp1.size()));
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) chk("wr0", got0[i], exp0[i]);
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) chk("wr1", got1[i], exp1[i]);
    chk("done0",  64'(done0), 64'(exp_done));
    chk("done1",  64'(done1), 64'(exp_done));
    chk("error0", 64'(b0.error), 64'(exp_err));
    chk("error1", 64'(b1.error), 64'(exp_err));
    chk("busy",   {62'd0, b1.busy, b0.busy}, 64'd0);
  endtask

  task automatic good_image(input logic [7:0] cs);
    stream.delete();
    stream.push_back(8'h04); stream.push_back(8'h00);
    for (int i = 0; i < 16; i++) stream.push_back(IMG[i]);
    stream.push_back(cs);
  endtask

  task automatic random_image();
    int         n;
    logic [7:0] x;
    stream.delete(); x = 8'h00;
    if ($urandom_range(0, 7) == 0) begin
      stream.push_back(8'($urandom)); stream.push_back(8'($urandom_range(1, 255)));
      return;
    end
    n = $urandom_range(0, MAXW + 1);
    stream.push_back(8'(n)); stream.push_back(8'h00);
    if (n == 0 || n > MAXW) return;
    for (int i = 0; i < 4 * n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      x ^= b;
      stream.push_back(b);
    end
    if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
    stream.push_back(x);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);

    good_image(8'h2E);
    load(0, -1, -1);
    for (int i = 0; i < got0.size() && got0.size() == 4; i++) chk("spec_word", got0[i], SPEC_W[i]);

    good_image(8'h2E);  load(2, 7, -1);
    good_image(8'h2F);  load(0, -1, -1);
    stream.delete(); stream.push_back(8'h00); stream.push_back(8'h00); load(0, -1, -1);
    stream.delete(); stream.push_back(8'h05); stream.push_back(8'h00); load(0, -1, -1);
    good_image(8'h2E);  load(0, -1, 8);
    chk("rst_partial_one_wr", (got0.size() == 1) ? got0[0] : 64'hDEAD, SPEC_W[0]);
    good_image(8'h2E);  load(0, -1, -1);

    stream.delete();
    stream.push_back(8'h01); stream.push_back(8'h00);
    stream.push_back(8'h13); stream.push_back(8'h00); stream.push_back(8'h00); stream.push_back(8'h00);
    stream.push_back(8'h13);
    load(0, -1, -1);
    chk("base100_wr", (got1.size() == 1) ? got1[0] : 64'hDEAD, {32'h100, 32'h00000013});

    for (int t = 0; t < 30; t++) begin
      random_image();
      load($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 5 : -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
